wb_mem_master: RTL and testbench

Wishbone bus master for the processor memory stage: accepts one load/store request at a time from the pipeline, drives a single Wishbone classic cycle on `mem_wb` toward a slave such as the on-chip RAM block, and returns width-adjusted, sign- or zero-extended read data with a one-cycle response pulse. It sits between the memory stage and the Wishbone interconnect. It rejects misaligned accesses without touching the bus.

---
 rtl/wb_pkg.sv | 32 +++
 rtl/wb_mem_master_if.sv | 16 +
 rtl/wb_load_extend.sv | 21 ++
 rtl/wb_mem_master.sv | 143 ++++++++++++++
 tb/tb_wb_mem_master.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone master types: access widths, master FSM states, default timeout
// and small address/width helpers.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_BYTE = 2'b00,
        WB_HALF = 2'b01,
        WB_WORD = 2'b10
    } wb_width_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } wb_mstate_t;

    localparam int WB_TIMEOUT_DEFAULT = 255;

    // Width code 11 has no meaning of its own and behaves as a word access.
    function automatic wb_width_t wb_norm_width(input logic [1:0] w);
        return (w == 2'b11) ? WB_WORD : wb_width_t'(w);
    endfunction

    function automatic logic wb_misaligned(input wb_width_t w, input logic [1:0] a);
        case (w)
            WB_HALF: return a[0];
            WB_WORD: return (a != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_mem_master_if.sv
// Wishbone classic bus bundle between a memory-stage master and a slave.
interface WISHBONE_IF;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        ack;

    modport master (output cyc, stb, we, addr, width, data_write,
                    input  data_read, ack);
    modport slave  (input  cyc, stb, we, addr, width, data_write,
                    output data_read, ack);
endinterface

// File: rtl/wb_load_extend.sv
// Right-justified load data extension: byte/half are sign- or zero-extended,
// word passes through unchanged.
module wb_load_extend
    import wb_pkg::*;
(
    input  wb_width_t   width,
    input  logic        is_unsigned,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (width)
            WB_BYTE: ext = {{24{raw[7]  & ~is_unsigned}}, raw[7:0]};
            WB_HALF: ext = {{16{raw[15] & ~is_unsigned}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/wb_mem_master.sv
// Memory-stage Wishbone classic master: one load/store at a time, misalignment
// rejected without a bus cycle. Optional BUS watchdog enabled by WB_TIMEOUT_EN.
module wb_mem_master
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_width,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    WISHBONE_IF.master  mem_wb
);

    wb_mstate_t  state, state_n;
    logic        we_q, uns_q, err_q;
    logic [31:0] addr_q, wdata_q, rdata_q, rdata_ext;
    wb_width_t   width_q, req_width_n;
    logic        req_misaligned;
    logic        tmo_expire;

    assign req_width_n    = wb_norm_width(req_width);
    assign req_misaligned = wb_misaligned(req_width_n, req_addr[1:0]);

`ifdef WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge iClk) begin
        if (iRst || state != BUS)
            tmo_cnt <= '0;
        else if (!mem_wb.ack)
            tmo_cnt <= tmo_cnt + TW'(1);
    end

    // Expire on the cycle whose increment would reach the limit; ack wins.
    assign tmo_expire = (state == BUS) && !mem_wb.ack &&
                        (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_expire = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (iRst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = req_misaligned ? RESP : BUS;
            BUS:     if (mem_wb.ack || tmo_expire) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            width_q <= WB_BYTE;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    uns_q   <= req_unsigned;
                    err_q   <= req_misaligned;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    width_q <= req_width_n;
                end
                BUS: if (mem_wb.ack) begin
                    rdata_q <= mem_wb.data_read;
                    err_q   <= 1'b0;
                end else if (tmo_expire) begin
                    err_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    wb_load_extend u_ext (
        .width       (width_q),
        .is_unsigned (uns_q),
        .raw         (rdata_q),
        .ext         (rdata_ext)
    );

    always_comb begin
        req_ready         = 1'b0;
        busy              = 1'b0;
        rsp_valid         = 1'b0;
        rsp_err           = 1'b0;
        rsp_rdata         = '0;
        mem_wb.cyc        = 1'b0;
        mem_wb.stb        = 1'b0;
        mem_wb.we         = 1'b0;
        mem_wb.addr       = '0;
        mem_wb.width      = 2'b00;
        mem_wb.data_write = '0;
        case (state)
            IDLE: req_ready = 1'b1;
            BUS: begin
                busy         = 1'b1;
                mem_wb.cyc   = 1'b1;
                mem_wb.stb   = 1'b1;
                mem_wb.we    = we_q;
                mem_wb.addr  = addr_q;
                mem_wb.width = width_q;
                case (width_q)
                    WB_BYTE: mem_wb.data_write = {24'd0, wdata_q[7:0]};
                    WB_HALF: mem_wb.data_write = {16'd0, wdata_q[15:0]};
                    default: mem_wb.data_write = wdata_q;
                endcase
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (we_q || err_q) ? 32'd0 : rdata_ext;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_mem_master.sv
// Directed bench for wb_mem_master with a byte-addressed slave model that can
// insert wait states or withhold ack entirely.
module tb_wb_mem_master;
    import wb_pkg::*;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_width = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    WISHBONE_IF bus();

    wb_mem_master #(.TIMEOUT_CYCLES(4)) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_width    (req_width),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .mem_wb       (bus)
    );

    always #5 iClk = ~iClk;

    // Slave: right-justified data, junk on unused upper lanes of narrow reads.
    logic [7:0]  mem [0:255];
    logic [7:0]  sa;
    logic [31:0] srd;
    int          waits = 0;
    int          wcnt = 0;
    logic        no_ack = 1'b0;

    always_comb begin
        sa = bus.addr[7:0];
        case (bus.width)
            2'b00:   srd = {24'hA5A5A5, mem[sa]};
            2'b01:   srd = {16'hA5A5, mem[sa + 8'd1], mem[sa]};
            default: srd = {mem[sa + 8'd3], mem[sa + 8'd2], mem[sa + 8'd1], mem[sa]};
        endcase
    end
    assign bus.data_read = srd;
    assign bus.ack = bus.cyc & bus.stb & ~no_ack & (wcnt >= waits);

    always @(posedge iClk) begin
        if (bus.cyc && bus.stb && !bus.ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (bus.cyc && bus.stb && bus.ack && bus.we) begin
            mem[sa] <= bus.data_write[7:0];
            if (bus.width != 2'b00) mem[sa + 8'd1] <= bus.data_write[15:8];
            if (bus.width[1]) begin
                mem[sa + 8'd2] <= bus.data_write[23:16];
                mem[sa + 8'd3] <= bus.data_write[31:24];
            end
        end
    end

    int vecs = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Presents a request for one edge; returns in cycle 1 after acceptance.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] w,
                         input logic uns, input logic [31:0] d);
        req_we = we; req_addr = addr; req_width = w; req_unsigned = uns; req_wdata = d;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] w,
                            input logic uns, input logic [31:0] exp);
        issue(1'b0, addr, w, uns, 32'h0);
        chk({tag, "_cyc"}, bus.cyc, 1);
        step();
        chk({tag, "_vld"}, rsp_valid, 1);
        chk({tag, "_data"}, rsp_rdata, exp);
        chk({tag, "_err"}, rsp_err, 0);
        step();
    endtask

    initial begin
        int seen;
        iRst = 1'b1;
        step(); step();
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cyc", bus.cyc, 0);
        chk("rst_stb", bus.stb, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_width", bus.width, 0);
        chk("rst_dw", bus.data_write, 0);
        chk("rst_rdata", rsp_rdata, 0);
        iRst = 1'b0;
        step();

        issue(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        chk("sw_cyc", bus.cyc, 1);
        chk("sw_stb", bus.stb, 1);
        chk("sw_we", bus.we, 1);
        chk("sw_width", bus.width, 2);
        chk("sw_addr", bus.addr, 32'h10);
        chk("sw_dw", bus.data_write, 32'hDEADBEEF);
        chk("sw_ready", req_ready, 0);
        chk("sw_busy", busy, 1);
        step();
        chk("sw_vld", rsp_valid, 1);
        chk("sw_err", rsp_err, 0);
        chk("sw_rdata", rsp_rdata, 0);
        chk("sw_cyc_off", bus.cyc, 0);
        step();
        chk("sw_idle_ready", req_ready, 1);
        chk("sw_idle_vld", rsp_valid, 0);

        load_chk("lw", 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);

        issue(1'b1, 32'h21, 2'b00, 1'b0, 32'h12345680);
        chk("sb_dw", bus.data_write, 32'h00000080);
        chk("sb_width", bus.width, 0);
        chk("sb_addr", bus.addr, 32'h21);
        step();
        chk("sb_vld", rsp_valid, 1);
        step();

        load_chk("lb_s", 32'h21, 2'b00, 1'b0, 32'hFFFFFF80);
        load_chk("lb_u", 32'h21, 2'b00, 1'b1, 32'h00000080);
        load_chk("lh_s", 32'h10, 2'b01, 1'b0, 32'hFFFFBEEF);
        load_chk("lh_u", 32'h10, 2'b01, 1'b1, 32'h0000BEEF);
        load_chk("lh_s2", 32'h12, 2'b01, 1'b0, 32'hFFFFDEAD);

        issue(1'b0, 32'h10, 2'b11, 1'b1, 32'h0);
        chk("lw11_width", bus.width, 2);
        step();
        chk("lw11_data", rsp_rdata, 32'hDEADBEEF);
        step();

        issue(1'b0, 32'h23, 2'b01, 1'b0, 32'h0);
        chk("mh_cyc", bus.cyc, 0);
        chk("mh_vld", rsp_valid, 1);
        chk("mh_err", rsp_err, 1);
        chk("mh_rdata", rsp_rdata, 0);
        step();
        chk("mh_ready", req_ready, 1);
        chk("mh_vld_off", rsp_valid, 0);

        issue(1'b1, 32'h12, 2'b10, 1'b0, 32'hCAFEF00D);
        chk("mw_cyc", bus.cyc, 0);
        chk("mw_err", rsp_err, 1);
        chk("mw_rdata", rsp_rdata, 0);
        step();

        waits = 3;
        issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("ws_stb", bus.stb, 1);
            chk("ws_addr", bus.addr, 32'h10);
            chk("ws_ready", req_ready, 0);
            chk("ws_vld", rsp_valid, 0);
            step();
        end
        chk("ws_rsp_vld", rsp_valid, 1);
        chk("ws_rsp_data", rsp_rdata, 32'hDEADBEEF);
        chk("ws_rsp_ready", req_ready, 0);
        step();
        waits = 0;

        no_ack = 1'b1;
        issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
`ifdef WB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            chk("to_cyc_on", bus.cyc, 1);
            step();
        end
        chk("to_cyc_off", bus.cyc, 0);
        chk("to_vld", rsp_valid, 1);
        chk("to_err", rsp_err, 1);
        chk("to_rdata", rsp_rdata, 0);
        step();
        issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        step();
`else
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            if (rsp_valid) seen++;
            step();
        end
        chk("hang_cyc", bus.cyc, 1);
        chk("hang_no_rsp", seen, 0);
`endif
        chk("rb_in_bus", bus.cyc, 1);
        iRst = 1'b1;
        step();
        chk("rb_cyc", bus.cyc, 0);
        chk("rb_stb", bus.stb, 0);
        chk("rb_vld", rsp_valid, 0);
        chk("rb_ready", req_ready, 1);
        iRst = 1'b0;
        no_ack = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rsp_valid) seen++;
        end
        chk("rb_no_rsp", seen, 0);

        load_chk("lw_after", 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
